// File: rtl/tick_bcd_display.sv
// tick_bcd_display: synchronizes the slow clock SCLK and turns each of its
// rising edges into a one-cycle STEP pulse. Each step advances a 4-digit BCD
// up/down counter, which is scanned onto a multiplexed 7-segment display.
module tick_bcd_display #(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCLK,
  input  logic        DIR,
  input  logic        HOLD,
  input  logic        CLR,
  output logic [15:0] COUNT,
  output logic        STEP,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  logic                    s1, s2, s3;
  logic                    rise;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [3:0]              blank;

  // BCD increment with ripple carry; 9999 wraps to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement with ripple borrow; 0000 wraps to 9999.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show nothing.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Three-flop synchronizer; left unreset so it tracks SCLK through reset.
  always_ff @(posedge CLK) begin
    s1 <= SCLK;
    s2 <= s1;
    s3 <= s2;
  end

  // Suppressing the edge during reset prevents a phantom step on release.
  assign rise = s2 & ~s3 & ~RST;

  // Step pulse and counter update with CLR > HOLD > edge priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      COUNT <= 16'h0000;
      STEP  <= 1'b0;
    end else begin
      STEP <= rise;
      if (CLR) begin
        COUNT <= 16'h0000;
      end else if (!HOLD && rise) begin
        COUNT <= DIR ? bcd_inc(COUNT) : bcd_dec(COUNT);
      end
    end
  end

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  // Pick the digit currently being scanned.
  always_comb begin
    digit = COUNT[3:0];
    case (sel)
      2'd1:    digit = COUNT[7:4];
      2'd2:    digit = COUNT[11:8];
      2'd3:    digit = COUNT[15:12];
      default: digit = COUNT[3:0];
    endcase
  end

  // A digit blanks only when it and every higher digit are zero; ones never blanks.
  assign blank[3] = BLANK_LZ && (COUNT[15:12] == 4'd0);
  assign blank[2] = blank[3] && (COUNT[11:8] == 4'd0);
  assign blank[1] = blank[2] && (COUNT[7:4] == 4'd0);
  assign blank[0] = 1'b0;

  // Free-running refresh counter and registered digit/segment/DP drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      refresh <= '0;
      AN      <= 4'b1111;
      SEG     <= 7'b1111111;
      DP      <= 1'b1;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      if (blank[sel]) begin
        AN  <= 4'b1111;
        SEG <= 7'b1111111;
      end else begin
        AN  <= ~(4'b0001 << sel);
        SEG <= seg7(digit);
      end
      DP <= ~((sel == 2'd0) && HOLD);
    end
  end

endmodule

// File: tb/tb_tick_bcd_display.sv
// Directed testbench for tick_bcd_display: table-driven step vectors and
// display-scan vectors, plus hand-written reset and CLR/edge sequences.
module tb_tick_bcd_display;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SCLK = 1'b0;
  logic        DIR = 1'b1;
  logic        HOLD = 1'b0;
  logic        CLR = 1'b0;
  logic [15:0] COUNT, count0;
  logic        STEP, step0;
  logic [3:0]  AN, an0;
  logic [6:0]  SEG, seg0;
  logic        DP, dp0;

  int nvec  = 0;
  int nfail = 0;

  logic [3:0] tb_ref = 4'd0;

  tick_bcd_display #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .DIR(DIR), .HOLD(HOLD), .CLR(CLR),
    .COUNT(COUNT), .STEP(STEP), .AN(AN), .SEG(SEG), .DP(DP)
  );

  tick_bcd_display #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .DIR(DIR), .HOLD(HOLD), .CLR(CLR),
    .COUNT(count0), .STEP(step0), .AN(an0), .SEG(seg0), .DP(dp0)
  );

  always #5 CLK = ~CLK;

  // Reference scan position: cleared by reset, advances every clock.
  always @(posedge CLK) tb_ref <= RST ? 4'd0 : tb_ref + 4'd1;

  typedef struct {
    bit          dir;
    bit          hold;
    bit          clr;
    logic [15:0] cnt;
  } step_vec_t;

  typedef struct {
    int          n;
    bit          lz;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
  } disp_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a negedge; leaves RST low at a negedge.
  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One SCLK period: high 4 clocks, low 4 clocks. Reports pulses and latency.
  task automatic pulse(output int nst, output int lat);
    nst = 0;
    lat = 0;
    SCLK = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (STEP) begin
        nst++;
        if (lat == 0) lat = i;
      end
      if (i == 4) SCLK = 1'b0;
    end
  endtask

  step_vec_t sv[15];
  disp_vec_t dv[13];

  initial begin
    int nst, lat, cur_n, found, bad, seen, stepseen;
    logic [3:0] pv;

    sv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0001};
    sv[1]  = '{1'b1, 1'b0, 1'b0, 16'h0002};
    sv[2]  = '{1'b1, 1'b0, 1'b0, 16'h0003};
    sv[3]  = '{1'b0, 1'b0, 1'b0, 16'h0002};
    sv[4]  = '{1'b1, 1'b1, 1'b0, 16'h0002};
    sv[5]  = '{1'b0, 1'b1, 1'b0, 16'h0002};
    sv[6]  = '{1'b0, 1'b0, 1'b0, 16'h0001};
    sv[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000};
    sv[8]  = '{1'b0, 1'b0, 1'b0, 16'h9999};
    sv[9]  = '{1'b0, 1'b0, 1'b0, 16'h9998};
    sv[10] = '{1'b1, 1'b0, 1'b0, 16'h9999};
    sv[11] = '{1'b1, 1'b0, 1'b0, 16'h0000};
    sv[12] = '{1'b1, 1'b0, 1'b0, 16'h0001};
    sv[13] = '{1'b1, 1'b0, 1'b1, 16'h0000};
    sv[14] = '{1'b1, 1'b0, 1'b0, 16'h0001};

    dv[0]  = '{0,   1'b1, 2'd0, 4'b1110, 7'b1000000};
    dv[1]  = '{0,   1'b1, 2'd1, 4'b1111, 7'b1111111};
    dv[2]  = '{0,   1'b1, 2'd3, 4'b1111, 7'b1111111};
    dv[3]  = '{0,   1'b0, 2'd1, 4'b1101, 7'b1000000};
    dv[4]  = '{42,  1'b1, 2'd0, 4'b1110, 7'b0100100};
    dv[5]  = '{42,  1'b1, 2'd1, 4'b1101, 7'b0011001};
    dv[6]  = '{42,  1'b1, 2'd2, 4'b1111, 7'b1111111};
    dv[7]  = '{42,  1'b1, 2'd3, 4'b1111, 7'b1111111};
    dv[8]  = '{42,  1'b0, 2'd2, 4'b1011, 7'b1000000};
    dv[9]  = '{42,  1'b0, 2'd3, 4'b0111, 7'b1000000};
    dv[10] = '{100, 1'b1, 2'd1, 4'b1101, 7'b1000000};
    dv[11] = '{100, 1'b1, 2'd2, 4'b1011, 7'b1111001};
    dv[12] = '{100, 1'b1, 2'd3, 4'b1111, 7'b1111111};

    // Reset state
    do_reset();
    chk("rst_count", COUNT, 16'h0000);
    chk("rst_step", STEP, 1'b0);
    chk("rst_an", AN, 4'b1111);
    chk("rst_seg", SEG, 7'b1111111);
    chk("rst_dp", DP, 1'b1);
    chk("rst_dp0", dp0, 1'b1);
    chk("rst_step0", step0, 1'b0);
    cyc();
    chk("first_scan_an", AN, 4'b1110);
    chk("first_scan_seg", SEG, 7'b1000000);

    // Step vectors from 0000
    for (int i = 0; i < 15; i++) begin
      DIR = sv[i].dir;
      HOLD = sv[i].hold;
      CLR = sv[i].clr;
      pulse(nst, lat);
      HOLD = 1'b0;
      CLR = 1'b0;
      chk($sformatf("vec%0d_count", i), COUNT, sv[i].cnt);
      chk($sformatf("vec%0d_steps", i), nst, 1);
      chk($sformatf("vec%0d_latency", i), lat, 3);
    end

    // DP lit only on the ones digit while HOLD is high
    HOLD = 1'b1;
    cyc();
    cyc();
    bad = 0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (AN == 4'b1110) begin
        seen++;
        if (DP !== 1'b0) bad++;
      end else if (DP !== 1'b1) begin
        bad++;
      end
    end
    HOLD = 1'b0;
    chk("dp_hold_errors", bad, 0);
    chk("dp_hold_ones_cycles", seen, 4);
    cyc();
    chk("dp_released", DP, 1'b1);

    // Display scan vectors
    cur_n = -1;
    DIR = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (dv[i].n != cur_n) begin
        do_reset();
        for (int k = 0; k < dv[i].n; k++) pulse(nst, lat);
        cur_n = dv[i].n;
        chk($sformatf("disp_setup_count_%0d", cur_n), COUNT, to_bcd(cur_n));
        chk($sformatf("disp_setup_count0_%0d", cur_n), count0, to_bcd(cur_n));
      end
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
        cyc();
        pv = tb_ref - 4'd1;
        if (pv[3:2] == dv[i].sel) found = 1;
      end
      chk($sformatf("disp%0d_sel_reached", i), found, 1);
      if (dv[i].lz) begin
        chk($sformatf("disp%0d_an", i), AN, dv[i].an);
        chk($sformatf("disp%0d_seg", i), SEG, dv[i].seg);
        chk($sformatf("disp%0d_dp", i), DP, 1'b1);
      end else begin
        chk($sformatf("disp%0d_an", i), an0, dv[i].an);
        chk($sformatf("disp%0d_seg", i), seg0, dv[i].seg);
        chk($sformatf("disp%0d_dp", i), dp0, 1'b1);
      end
    end

    // CLR in the same cycle as the edge, from 0057
    do_reset();
    DIR = 1'b1;
    for (int k = 0; k < 57; k++) pulse(nst, lat);
    chk("clr_pre_count", COUNT, 16'h0057);
    SCLK = 1'b1;
    cyc();
    cyc();
    chk("clr_step_not_yet", STEP, 1'b0);
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    chk("clr_edge_count", COUNT, 16'h0000);
    chk("clr_edge_step", STEP, 1'b1);
    cyc();
    chk("clr_step_width", STEP, 1'b0);
    SCLK = 1'b0;
    repeat (4) cyc();
    chk("clr_count_stays", COUNT, 16'h0000);

    // Reset mid-count with SCLK held high
    for (int k = 0; k < 5; k++) pulse(nst, lat);
    chk("midrst_pre_count", COUNT, 16'h0005);
    SCLK = 1'b1;
    RST = 1'b1;
    repeat (5) cyc();
    chk("midrst_count", COUNT, 16'h0000);
    chk("midrst_step", STEP, 1'b0);
    chk("midrst_an", AN, 4'b1111);
    chk("midrst_seg", SEG, 7'b1111111);
    chk("midrst_dp", DP, 1'b1);
    RST = 1'b0;
    stepseen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (STEP) stepseen++;
    end
    chk("postrst_no_step", stepseen, 0);
    chk("postrst_count", COUNT, 16'h0000);
    SCLK = 1'b0;
    repeat (4) cyc();
    pulse(nst, lat);
    chk("postrst_real_steps", nst, 1);
    chk("postrst_real_latency", lat, 3);
    chk("postrst_real_count", COUNT, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
